// File: rtl/mdu_ctrl_if.sv
// Execute-stage multiply/divide bus: issue, operands, status and HI/LO readout.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        isMD_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  modport master (
    output start, md_op, A, B, isMD_D,
    input  busy, stall_md, HI, LO, md_out
  );

  modport slave (
    input  start, md_op, A, B, isMD_D,
    output busy, stall_md, HI, LO, md_out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit: HI/LO owner with fixed-latency down-counter sequencing.
//   state  | meaning
//   S_IDLE | no operation in flight; mthi/mtlo accepted, new start accepted
//   S_BUSY | counting down; pending result commits when counter reaches 1
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   md
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_keep;

  logic        op_arith, op_div, div_zero, div_ovf;
  logic [31:0] div_b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [63:0] result;

  always_comb begin
    op_arith = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
    op_div   = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
    div_zero = (md.B == 32'd0);
    // Substitute divisor keeps the datapath defined; the result is discarded anyway.
    div_b    = div_zero ? 32'd1 : md.B;
    div_ovf  = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);
    prod_s   = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    prod_u   = {32'd0, md.A} * {32'd0, md.B};
    q_s      = div_ovf ? 32'h8000_0000 : 32'($signed(md.A) / $signed(div_b));
    r_s      = div_ovf ? 32'd0 : 32'($signed(md.A) % $signed(div_b));
    q_u      = md.A / div_b;
    r_u      = md.A % div_b;
    result   = 64'd0;
    case (md.md_op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {r_s, q_s};
      OP_DIVU:  result = {r_u, q_u};
      default:  result = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_keep <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md.start && op_arith) begin
            pend_hi   <= result[63:32];
            pend_lo   <= result[31:0];
            pend_keep <= op_div && div_zero;
            cnt       <= op_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
            state     <= S_BUSY;
          end else if (!md.start && md.md_op == OP_MTHI) begin
            hi <= md.A;
          end else if (!md.start && md.md_op == OP_MTLO) begin
            lo <= md.A;
          end
        end
        S_BUSY: begin
          if (cnt == 8'd1) begin
            if (!pend_keep) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= 8'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md.busy     = (state == S_BUSY);
  assign md.HI       = hi;
  assign md.LO       = lo;
  assign md.stall_md = md.isMD_D & (md.busy | md.start);

  always_comb begin
    md.md_out = 32'd0;
    if (md.md_op == OP_MFHI)      md.md_out = hi;
    else if (md.md_op == OP_MFLO) md.md_out = lo;
  end

  // A start while busy is dropped by the FSM; flag it so pipeline bugs surface.
  start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(md.start && md.busy))
    else $warning("mdu_ctrl: start issued while busy, ignored");

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mdu_ctrl_if md();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    md.start = 1'b0; md.md_op = 4'd0; md.A = 32'd0; md.B = 32'd0; md.isMD_D = 1'b0;
  endtask

  // Drives a start in cycle 0 and returns in cycle 1 with start released.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = 1'b1; md.md_op = op; md.A = a; md.B = b;
    step();
    md.start = 1'b0; md.md_op = 4'd0; md.A = 32'd0; md.B = 32'd0;
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] a);
    md.md_op = op; md.A = a;
    step();
    md.md_op = 4'd0; md.A = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    md.start = 1'b1; md.md_op = 4'd1; md.A = 32'd3; md.B = 32'd4; md.isMD_D = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d busy=%b HI=%h LO=%h exp busy=0 HI=0 LO=0", i, md.busy, md.HI, md.LO);
      end
    end
    reset = 1'b1;
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (md.busy !== 1'b0 || md.LO !== 32'd0) begin
        errors++;
        $display("FAIL reset_release cyc %0d busy=%b LO=%h exp busy=0 LO=0", i, md.busy, md.LO);
      end
    end
  endtask

  task automatic test_mult_latency();
    move(4'd7, 32'h1111_1111);
    move(4'd8, 32'h2222_2222);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (md.busy !== 1'b1 || md.HI !== 32'h1111_1111 || md.LO !== 32'h2222_2222) begin
        errors++;
        $display("FAIL mult_busy cyc %0d busy=%b HI=%h LO=%h exp busy=1 HI=11111111 LO=22222222", c, md.busy, md.HI, md.LO);
      end
      step();
    end
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'hFFFF_FFFF || md.LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_commit busy=%b HI=%h LO=%h exp busy=0 HI=ffffffff LO=fffffffa", md.busy, md.HI, md.LO);
    end
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    repeat (5) step();
    checks++;
    if (md.HI !== 32'd1 || md.LO !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu HI=%h LO=%h exp HI=00000001 LO=fffffffe", md.HI, md.LO);
    end
  endtask

  task automatic test_divide();
    issue(4'd3, -32'sd7, 32'd2);
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (md.busy !== 1'b1) begin
        errors++;
        $display("FAIL div_busy cyc %0d busy=%b exp 1", c, md.busy);
      end
      step();
    end
    checks++;
    if (md.busy !== 1'b0 || md.LO !== 32'hFFFF_FFFD || md.HI !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_signed busy=%b HI=%h LO=%h exp busy=0 HI=ffffffff LO=fffffffd", md.busy, md.HI, md.LO);
    end
    issue(4'd4, 32'hFFFF_FFFF, 32'h10);
    repeat (10) step();
    checks++;
    if (md.LO !== 32'h0FFF_FFFF || md.HI !== 32'hF) begin
      errors++;
      $display("FAIL divu HI=%h LO=%h exp HI=0000000f LO=0fffffff", md.HI, md.LO);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) step();
    checks++;
    if (md.LO !== 32'h8000_0000 || md.HI !== 32'd0) begin
      errors++;
      $display("FAIL div_ovf HI=%h LO=%h exp HI=00000000 LO=80000000", md.HI, md.LO);
    end
    move(4'd7, 32'h55);
    move(4'd8, 32'h55);
    issue(4'd3, 32'h1234, 32'd0);
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (md.busy !== 1'b1) begin
        errors++;
        $display("FAIL divz_busy cyc %0d busy=%b exp 1", c, md.busy);
      end
      step();
    end
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'h55 || md.LO !== 32'h55) begin
      errors++;
      $display("FAIL divz_keep busy=%b HI=%h LO=%h exp busy=0 HI=00000055 LO=00000055", md.busy, md.HI, md.LO);
    end
  endtask

  task automatic test_stall_move();
    md.isMD_D = 1'b1;
    md.start = 1'b1; md.md_op = 4'd1; md.A = 32'd7; md.B = 32'd9;
    #1;
    checks++;
    if (md.stall_md !== 1'b1) begin
      errors++;
      $display("FAIL stall cyc 0 got %b exp 1", md.stall_md);
    end
    step();
    md.start = 1'b0; md.md_op = 4'd0; md.A = 32'd0; md.B = 32'd0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++;
      if (md.stall_md !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc %0d got %b exp 1", c, md.stall_md);
      end
      step();
    end
    #1;
    checks++;
    if (md.stall_md !== 1'b0 || md.busy !== 1'b0 || md.LO !== 32'd63) begin
      errors++;
      $display("FAIL stall_release stall=%b busy=%b LO=%h exp stall=0 busy=0 LO=0000003f", md.stall_md, md.busy, md.LO);
    end
    md.isMD_D = 1'b0;

    move(4'd7, 32'h1234);
    checks++;
    if (md.HI !== 32'h1234) begin
      errors++;
      $display("FAIL mthi HI=%h exp 00001234", md.HI);
    end
    md.md_op = 4'd5; #1;
    checks++;
    if (md.md_out !== 32'h1234) begin
      errors++;
      $display("FAIL mfhi md_out=%h exp 00001234", md.md_out);
    end
    move(4'd8, 32'hABCD);
    md.md_op = 4'd6; #1;
    checks++;
    if (md.md_out !== 32'hABCD) begin
      errors++;
      $display("FAIL mflo md_out=%h exp 0000abcd", md.md_out);
    end
    md.md_op = 4'd9; #1;
    checks++;
    if (md.md_out !== 32'd0) begin
      errors++;
      $display("FAIL md_out_none md_out=%h exp 00000000", md.md_out);
    end
    md.md_op = 4'd0;

    md.start = 1'b1; md.md_op = 4'd5;
    step();
    md.start = 1'b0; md.md_op = 4'd0;
    checks++;
    if (md.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_nonarith busy=%b exp 0", md.busy);
    end

    issue(4'd1, 32'd2, 32'd3);
    md.md_op = 4'd8; md.A = 32'hDEAD; #1;
    checks++;
    if (md.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_decode got %b exp 0", md.stall_md);
    end
    step();
    md.md_op = 4'd0; md.A = 32'd0;
    checks++;
    if (md.LO !== 32'hABCD) begin
      errors++;
      $display("FAIL mtlo_busy LO=%h exp 0000abcd", md.LO);
    end
    repeat (4) step();
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd6) begin
      errors++;
      $display("FAIL mult_after_mtlo busy=%b HI=%h LO=%h exp busy=0 HI=0 LO=6", md.busy, md.HI, md.LO);
    end
  endtask

  task automatic test_abort();
    logic dirty;
    move(4'd7, 32'hAAAA);
    move(4'd8, 32'hBBBB);
    issue(4'd3, 32'd100, 32'd7);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) begin
      errors++;
      $display("FAIL abort busy=%b HI=%h LO=%h exp busy=0 HI=0 LO=0", md.busy, md.HI, md.LO);
    end
    dirty = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) dirty = 1'b1;
    end
    checks++;
    if (dirty !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_commit late change seen=%b exp 0", dirty);
    end
  endtask

  task automatic test_back_to_back();
    issue(4'd1, 32'd6, 32'd7);
    step();
    md.start = 1'b1; md.md_op = 4'd1; md.A = 32'd100; md.B = 32'd100;
    step();
    md.start = 1'b0; md.md_op = 4'd0; md.A = 32'd0; md.B = 32'd0;
    repeat (3) step();
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd42) begin
      errors++;
      $display("FAIL ignored_start busy=%b HI=%h LO=%h exp busy=0 HI=0 LO=0000002a", md.busy, md.HI, md.LO);
    end
    step();
    checks++;
    if (md.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_idle busy=%b exp 0", md.busy);
    end
    issue(4'd4, 32'd100, 32'd7);
    repeat (10) step();
    checks++;
    if (md.busy !== 1'b0 || md.LO !== 32'd14 || md.HI !== 32'd2) begin
      errors++;
      $display("FAIL divu_followup busy=%b HI=%h LO=%h exp busy=0 HI=2 LO=0000000e", md.busy, md.HI, md.LO);
    end
  endtask

  initial begin
    idle_in();
    reset = 1'b0;
    test_reset();
    test_mult_latency();
    test_divide();
    test_stall_move();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
